// File: rtl/ascii_tolower_stream.sv
// Streaming ASCII lower-case converter with a 2-entry skid FIFO,
// optional backslash escape and a saturating conversion counter.
module ascii_tolower_stream #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             esc_en,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] conv_count
);

   typedef enum logic {NORM, ESC} state_t;

   state_t     state;
   logic [8:0] mem [2];
   logic       rd_ptr;
   logic       wr_ptr;
   logic [1:0] count;

   logic       push;
   logic       pop;
   logic       esc_act;
   logic       is_upper;
   logic       do_conv;
   logic [8:0] wr_cell;
   logic       head_conv;

   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign out_data  = mem[rd_ptr][8:1];
   assign head_conv = mem[rd_ptr][0];

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   // A dropped esc_en makes this cycle's push behave as in NORM.
   assign esc_act  = (state == ESC) & esc_en;
   assign is_upper = (in_data >= 8'h41) && (in_data <= 8'h5A);
   assign do_conv  = is_upper & ~esc_act;
   assign wr_cell  = do_conv ? {in_data | 8'h20, 1'b1}
                             : {in_data, 1'b0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_cell;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         unique case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= NORM;
      end else if (!esc_en) begin
         state <= NORM;
      end else if (push) begin
         if (state == ESC)
            state <= NORM;
         else if (in_data == 8'h5C)
            state <= ESC;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         conv_count <= '0;
      else if (cnt_clr)
         conv_count <= '0;
      else if (pop && head_conv && (conv_count != '1))
         conv_count <= conv_count + 1'b1;
   end

endmodule
